// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants, FSM state type and frame helpers for the
// UART command parser (frame = SYNC, ADDR, DHI, DLO, CHK).
package uart_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;
  localparam logic [BYTE_W-1:0] ACK_BYTE  = 8'h06;
  localparam logic [BYTE_W-1:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DHI,
    GET_DLO,
    GET_CHK,
    RESP_ISSUE,
    RESP_HOLD
  } state_e;

  // Frame checksum: XOR of the three payload bytes.
  function automatic logic [BYTE_W-1:0] frame_chk(input logic [BYTE_W-1:0] addr,
                                                  input logic [BYTE_W-1:0] dhi,
                                                  input logic [BYTE_W-1:0] dlo);
    return addr ^ dhi ^ dlo;
  endfunction

endpackage

// File: rtl/uart_cmd_tx_seq.sv
// uart_cmd_tx_seq: transmit handshake for one response byte at a time.
// Ports:
//   input_clk, reset   clock, async active-low reset
//   byte_valid         response byte is waiting to be issued (RESP_ISSUE)
//   byte_data          the response byte
//   byte_ready_c       byte accepted this cycle (comb), tx_en follows next cycle
//   hold_active        parser is waiting for the transmitter to pick up (RESP_HOLD)
//   hold_done_c        hold phase ends this cycle (comb)
//   tx_busy            transmitter busy
//   tx_en, tx_data     registered one-cycle transmit request and its byte
module uart_cmd_tx_seq
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TX_GUARD = 16
) (
  input  logic              input_clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready_c,
  input  logic              hold_active,
  output logic              hold_done_c,
  input  logic              tx_busy,
  output logic              tx_en,
  output logic [BYTE_W-1:0] tx_data
);

  localparam int unsigned GUARD_W = $clog2(TX_GUARD + 1);

  logic [GUARD_W-1:0] guard_cnt_q;

  // Issue only into an idle transmitter; hold ends when it goes busy or the guard expires.
  assign byte_ready_c = byte_valid && !tx_busy;
  assign hold_done_c  = hold_active && (tx_busy || (guard_cnt_q == GUARD_W'(TX_GUARD - 1)));

  // Request register and guard counter
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      tx_en       <= 1'b0;
      tx_data     <= '0;
      guard_cnt_q <= '0;
    end else begin
      tx_en <= byte_ready_c;
      if (byte_ready_c) begin
        tx_data <= byte_data;
      end
      if (hold_active && !hold_done_c) begin
        guard_cnt_q <= guard_cnt_q + GUARD_W'(1);
      end else begin
        guard_cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 5-byte command frames (A5, ADDR, DHI, DLO, CHK)
// from the UART receiver, turns good frames into register writes and answers
// every completed frame with ACK (0x06) or NAK (0x15).
// Ports:
//   input_clk, reset        clock, async active-low reset
//   rx_data, rx_valid       received byte and its one-cycle strobe
//   tx_busy                 transmitter busy
//   tx_en, tx_data          one-cycle transmit request and byte
//   reg_wr_en               one-cycle register write strobe
//   reg_addr, reg_wdata     register address / write data (held between accesses)
//   frame_err               one-cycle pulse on checksum error, rejected read or timeout
// Build option UART_CMD_READBACK_EN adds reg_rdata / reg_rd_en and answers
// ADDR[7]=1 frames with ACK, rdata[15:8], rdata[7:0].
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TX_GUARD       = 16
) (
  input  logic              input_clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic              tx_en,
  output logic [BYTE_W-1:0] tx_data,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              frame_err
`ifdef UART_CMD_READBACK_EN
  ,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              reg_rd_en
`endif
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q;
  state_e            state_d;
  logic [BYTE_W-1:0] addr_q;
  logic [BYTE_W-1:0] dhi_q;
  logic [BYTE_W-1:0] dlo_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [1:0]        resp_idx_q;
  logic              nak_q;
  logic              rd_resp_q;
  logic [DATA_W-1:0] resp_rdata;

  logic              in_get_c;
  logic              timeout_c;
  logic              chk_ok_c;
  logic              frame_done_c;
  logic              read_c;
  logic              accept_c;
  logic              resp_last_c;
  logic              wr_en_d;
  logic              rd_en_d;
  logic              err_d;
  logic [BYTE_W-1:0] resp_byte_c;
  logic              issue_c;
  logic              hold_c;
  logic              byte_ready_c;
  logic              hold_done_c;

  assign in_get_c  = (state_q == GET_ADDR) || (state_q == GET_DHI) ||
                     (state_q == GET_DLO)  || (state_q == GET_CHK);
  // Expiry beats a byte strobe arriving in the same cycle.
  assign timeout_c = in_get_c && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign issue_c   = (state_q == RESP_ISSUE);
  assign hold_c    = (state_q == RESP_HOLD);

  // State register
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = GET_ADDR;
      end
      GET_ADDR: begin
        if (timeout_c)     state_d = IDLE;
        else if (rx_valid) state_d = GET_DHI;
      end
      GET_DHI: begin
        if (timeout_c)     state_d = IDLE;
        else if (rx_valid) state_d = GET_DLO;
      end
      GET_DLO: begin
        if (timeout_c)     state_d = IDLE;
        else if (rx_valid) state_d = GET_CHK;
      end
      GET_CHK: begin
        if (timeout_c)     state_d = IDLE;
        else if (rx_valid) state_d = RESP_ISSUE;
      end
      RESP_ISSUE: begin
        if (byte_ready_c) state_d = RESP_HOLD;
      end
      RESP_HOLD: begin
        if (hold_done_c) state_d = resp_last_c ? IDLE : RESP_ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath decode
  always_comb begin
    chk_ok_c     = (rx_data == frame_chk(addr_q, dhi_q, dlo_q));
    frame_done_c = (state_q == GET_CHK) && rx_valid && !timeout_c;
    read_c       = addr_q[BYTE_W-1];
`ifdef UART_CMD_READBACK_EN
    accept_c     = chk_ok_c;
`else
    accept_c     = chk_ok_c && !read_c;
`endif
    wr_en_d      = frame_done_c && accept_c && !read_c;
    rd_en_d      = frame_done_c && accept_c && read_c;
    err_d        = timeout_c || (frame_done_c && !accept_c);
    resp_last_c  = rd_resp_q ? (resp_idx_q == 2'd2) : 1'b1;
    case (resp_idx_q)
      2'd0:    resp_byte_c = nak_q ? NAK_BYTE : ACK_BYTE;
      2'd1:    resp_byte_c = resp_rdata[DATA_W-1:BYTE_W];
      default: resp_byte_c = resp_rdata[BYTE_W-1:0];
    endcase
  end

  // Frame capture, timeout counter, register-port and response bookkeeping
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      dhi_q      <= '0;
      dlo_q      <= '0;
      to_cnt_q   <= '0;
      resp_idx_q <= '0;
      nak_q      <= 1'b0;
      rd_resp_q  <= 1'b0;
      reg_wr_en  <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      frame_err  <= 1'b0;
    end else begin
      reg_wr_en <= wr_en_d;
      frame_err <= err_d;

      if (!in_get_c || rx_valid || timeout_c) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end

      if (rx_valid && !timeout_c) begin
        case (state_q)
          GET_ADDR: addr_q <= rx_data;
          GET_DHI:  dhi_q  <= rx_data;
          GET_DLO:  dlo_q  <= rx_data;
          default:  ;
        endcase
      end

      if (wr_en_d || rd_en_d) begin
        reg_addr <= addr_q[ADDR_W-1:0];
      end
      if (wr_en_d) begin
        reg_wdata <= {dhi_q, dlo_q};
      end

      if (frame_done_c) begin
        nak_q      <= !accept_c;
        rd_resp_q  <= rd_en_d;
        resp_idx_q <= '0;
      end else if (hold_done_c && !resp_last_c) begin
        resp_idx_q <= resp_idx_q + 2'd1;
      end
    end
  end

`ifdef UART_CMD_READBACK_EN
  logic              rd_sample_q;
  logic [DATA_W-1:0] rdata_q;

  // Read strobe, then capture read data on the cycle after it.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      reg_rd_en   <= 1'b0;
      rd_sample_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      reg_rd_en   <= rd_en_d;
      rd_sample_q <= reg_rd_en;
      if (rd_sample_q) begin
        rdata_q <= reg_rdata;
      end
    end
  end

  assign resp_rdata = rdata_q;
`else
  assign resp_rdata = '0;
`endif

  uart_cmd_tx_seq #(
    .TX_GUARD(TX_GUARD)
  ) u_tx_seq (
    .input_clk   (input_clk),
    .reset       (reset),
    .byte_valid  (issue_c),
    .byte_data   (resp_byte_c),
    .byte_ready_c(byte_ready_c),
    .hold_active (hold_c),
    .hold_done_c (hold_done_c),
    .tx_busy     (tx_busy),
    .tx_en       (tx_en),
    .tx_data     (tx_data)
  );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: table of frames plus hand-written
// timeout, busy, reset and readback sequences, checked by a scoreboard.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int unsigned TO_CYC = 100;
  localparam int unsigned GUARD  = 16;

  logic        input_clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        reg_wr_en;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        frame_err;
`ifdef UART_CMD_READBACK_EN
  logic [15:0] reg_rdata;
  logic        reg_rd_en;
`endif

  always #5 input_clk = ~input_clk;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO_CYC), .TX_GUARD(GUARD)) dut (
    .input_clk(input_clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_busy  (tx_busy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .reg_wr_en(reg_wr_en),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .frame_err(frame_err)
`ifdef UART_CMD_READBACK_EN
    ,
    .reg_rdata(reg_rdata),
    .reg_rd_en(reg_rd_en)
`endif
  );

  // Transmitter model: busy for 10 cycles after each request, or forced.
  int unsigned busy_cnt = 0;
  logic        force_busy;
  always @(posedge input_clk) begin
    if (tx_en) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    string       name;
    logic [39:0] frame;
    logic        wr;
    logic [6:0]  addr;
    logic [15:0] data;
    logic [7:0]  resp;
    logic        err;
  } vec_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  bit         exp_err_q[$];
  logic [6:0] exp_rd[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int last_wr_cyc = -1000;
  int last_tx_cyc = -1000;
  int last_err_cyc = -1000;
  int tx_count = 0;
  logic [6:0]  model_addr = '0;
  logic [15:0] model_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got pulse want none", name);
  endtask

  // Advance to the next falling edge and score any output events.
  task automatic tick();
    wr_t w;
    @(negedge input_clk);
    cyc++;
    if (reg_wr_en === 1'b1) begin
      last_wr_cyc = cyc;
      if (exp_wr.size() == 0) unexpected("reg_wr_en");
      else begin
        w = exp_wr.pop_front();
        check("wr_addr", 32'(reg_addr), 32'(w.addr));
        check("wr_data", 32'(reg_wdata), 32'(w.data));
      end
    end
    if (tx_en === 1'b1) begin
      last_tx_cyc = cyc;
      tx_count++;
      if (exp_tx.size() == 0) unexpected("tx_en");
      else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
    end
    if (frame_err === 1'b1) begin
      last_err_cyc = cyc;
      if (exp_err_q.size() == 0) unexpected("frame_err");
      else void'(exp_err_q.pop_front());
    end
`ifdef UART_CMD_READBACK_EN
    if (reg_rd_en === 1'b1) begin
      if (exp_rd.size() == 0) unexpected("reg_rd_en");
      else check("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
    end
`endif
  endtask

  function automatic int pending();
    return exp_wr.size() + exp_tx.size() + exp_err_q.size() + exp_rd.size();
  endfunction

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_data    = b;
    rx_valid   = 1'b1;
    strobe_cyc = cyc;
    tick();
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8]);
  endtask

  // Wait (bounded) for all expected events, then let the bus settle.
  task automatic drain(input string name);
    int n = 0;
    while (pending() != 0 && n < 400) begin
      tick();
      n++;
    end
    check({name, " drain"}, 32'(pending()), 32'd0);
    repeat (30) tick();
  endtask

  task automatic check_hold(input string name);
    check({name, " addr_hold"}, 32'(reg_addr), 32'(model_addr));
    check({name, " data_hold"}, 32'(reg_wdata), 32'(model_data));
  endtask

  task automatic run_frame(input string name, input logic [39:0] f, input logic wr,
                           input logic [6:0] addr, input logic [15:0] data,
                           input logic [7:0] resp, input logic err);
    wr_t w;
    int tx0;
    tx0 = tx_count;
    if (wr) begin
      w.addr = addr;
      w.data = data;
      exp_wr.push_back(w);
      model_addr = addr;
      model_data = data;
    end
    exp_tx.push_back(resp);
    if (err) exp_err_q.push_back(1'b1);
    send_frame(f);
    if (wr) check({name, " wr_latency"}, 32'(last_wr_cyc - strobe_cyc), 32'd1);
    drain(name);
    check({name, " tx_pulses"}, 32'(tx_count - tx0), 32'd1);
    check({name, " tx_latency>=2"}, 32'(last_tx_cyc - strobe_cyc >= 2), 32'd1);
    check_hold(name);
  endtask

  function automatic vec_t mk(input string name, input logic [39:0] f, input logic wr,
                              input logic [6:0] addr, input logic [15:0] data,
                              input logic [7:0] resp, input logic err);
    vec_t v;
    v.name = name; v.frame = f; v.wr = wr; v.addr = addr;
    v.data = data; v.resp = resp; v.err = err;
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    int tx0;
    vecs[0] = mk("ack_basic",  40'hA5_12_34_56_70, 1'b1, 7'h12, 16'h3456, 8'h06, 1'b0);
    vecs[1] = mk("bad_chk",    40'hA5_12_34_56_71, 1'b0, 7'h00, 16'h0000, 8'h15, 1'b1);
    vecs[2] = mk("small",      40'hA5_01_00_02_03, 1'b1, 7'h01, 16'h0002, 8'h06, 1'b0);
    vecs[3] = mk("max_addr",   40'hA5_7F_FF_FF_7F, 1'b1, 7'h7F, 16'hFFFF, 8'h06, 1'b0);
    vecs[4] = mk("all_zero",   40'hA5_00_00_00_00, 1'b1, 7'h00, 16'h0000, 8'h06, 1'b0);
    vecs[5] = mk("sync_data",  40'hA5_20_A5_A5_20, 1'b1, 7'h20, 16'hA5A5, 8'h06, 1'b0);

    reset      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    force_busy = 1'b0;
`ifdef UART_CMD_READBACK_EN
    reg_rdata  = 16'h0000;
`endif
    repeat (3) tick();
    check("rst tx_en",     32'(tx_en),     32'd0);
    check("rst tx_data",   32'(tx_data),   32'd0);
    check("rst reg_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst reg_addr",  32'(reg_addr),  32'd0);
    check("rst reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst frame_err", 32'(frame_err), 32'd0);
    reset = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].name, vecs[i].frame, vecs[i].wr, vecs[i].addr,
                vecs[i].data, vecs[i].resp, vecs[i].err);
    end

    // Leading junk before the sync byte is ignored.
    send_byte(8'h00);
    send_byte(8'hFF);
    run_frame("junk_prefix", 40'hA5_01_00_02_03, 1'b1, 7'h01, 16'h0002, 8'h06, 1'b0);

    // Partial frame times out: frame_err 100 idle cycles later, no response.
    tx0 = tx_count;
    exp_err_q.push_back(1'b1);
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int n = 0; n < 200 && exp_err_q.size() != 0; n++) tick();
    check("timeout seen", 32'(exp_err_q.size()), 32'd0);
    check("timeout delay", 32'(last_err_cyc - strobe_cyc), 32'(TO_CYC + 1));
    repeat (30) tick();
    check("timeout no_tx", 32'(tx_count - tx0), 32'd0);
    run_frame("after_timeout", 40'hA5_12_34_56_70, 1'b1, 7'h12, 16'h3456, 8'h06, 1'b0);

    // Transmitter busy for 500 cycles: exactly one request after it frees up.
    begin
      wr_t w;
      w.addr = 7'h12; w.data = 16'h3456;
      tx0 = tx_count;
      force_busy = 1'b1;
      exp_wr.push_back(w);
      exp_tx.push_back(8'h06);
      send_frame(40'hA5_12_34_56_70);
      repeat (500) tick();
      check("busy no_tx", 32'(tx_count - tx0), 32'd0);
      force_busy = 1'b0;
      drain("busy");
      check("busy tx_pulses", 32'(tx_count - tx0), 32'd1);
    end

    // Bytes arriving while a response is pending are dropped.
    begin
      wr_t w;
      w.addr = 7'h12; w.data = 16'h3456;
      tx0 = tx_count;
      force_busy = 1'b1;
      exp_wr.push_back(w);
      exp_tx.push_back(8'h06);
      send_frame(40'hA5_12_34_56_70);
      send_frame(40'hA5_01_00_02_03);
      force_busy = 1'b0;
      drain("resp_drop");
      check("resp_drop tx_pulses", 32'(tx_count - tx0), 32'd1);
      check_hold("resp_drop");
    end

    // Reset in the middle of a frame discards it; tail bytes are junk.
    tx0 = tx_count;
    send_byte(8'hA5);
    send_byte(8'h12);
    reset = 1'b0;
    tick();
    tick();
    check("midrst reg_addr",  32'(reg_addr),  32'd0);
    check("midrst reg_wdata", 32'(reg_wdata), 32'd0);
    check("midrst tx_en",     32'(tx_en),     32'd0);
    model_addr = '0;
    model_data = '0;
    reset = 1'b1;
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h70);
    repeat (30) tick();
    check("midrst no_tx", 32'(tx_count - tx0), 32'd0);
    run_frame("after_reset", 40'hA5_12_34_56_70, 1'b1, 7'h12, 16'h3456, 8'h06, 1'b0);

`ifdef UART_CMD_READBACK_EN
    // Read frame: read strobe at 0x05, response ACK, BE, EF.
    tx0 = tx_count;
    reg_rdata = 16'hBEEF;
    exp_rd.push_back(7'h05);
    exp_tx.push_back(8'h06);
    exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hEF);
    send_frame(40'hA5_85_00_00_85);
    drain("readback");
    check("readback tx_pulses", 32'(tx_count - tx0), 32'd3);
    model_addr = 7'h05;
    check_hold("readback");
`else
    // Read flag without readback support is rejected.
    run_frame("read_flag", 40'hA5_85_00_00_85, 1'b0, 7'h00, 16'h0000, 8'h15, 1'b1);
    run_frame("read_flag0", 40'hA5_80_12_34_A6, 1'b0, 7'h00, 16'h0000, 8'h15, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receive/transmit wrapper in the logic-analyzer control path.
- Consumes received bytes (data_received / one-cycle data_rdy) and assembles fixed 5-byte command frames.
- Valid frames become register-write strobes for the capture configuration registers.
- Each frame is answered with ACK or NAK through the wrapper's trans_en/data_out/tx_busy transmit interface.

Parameters:
- TIMEOUT_CYCLES, 1000000: maximum input_clk cycles between bytes of one frame before the partial frame is discarded.
- TX_GUARD, 16: maximum cycles to wait for tx_busy to rise after a tx_en pulse.

Ports:
- input_clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte (from data_rdy).
- tx_busy  in  1  transmitter busy.
- tx_en  out  1  one-cycle transmit request (to trans_en).
- tx_data  out  8  byte to transmit (to data_out); held stable while tx_en=1.
- reg_wr_en  out  1  one-cycle register write strobe.
- reg_addr  out  7  register address.
- reg_wdata  out  16  register write data.
- frame_err  out  1  one-cycle pulse on checksum error or timeout.

Behaviour:
- Reset: async assert, sync deassert. All outputs 0, FSM in IDLE, byte and timeout counters cleared.
- Frame format: SYNC=0xA5, ADDR, DHI, DLO, CHK. CHK = ADDR ^ DHI ^ DLO. ADDR[6:0] is the address; ADDR[7] is the read flag (optional feature only; otherwise must be 0).
- FSM states: IDLE, GET_ADDR, GET_DHI, GET_DLO, GET_CHK, RESP_ISSUE, RESP_HOLD.
- IDLE: a byte other than 0xA5 is discarded silently. 0xA5 -> GET_ADDR.
- GET_* states: each rx_valid latches the byte and advances one state.
- Timeout counter: cleared on every rx_valid, counts in GET_* states. Reaching TIMEOUT_CYCLES-1 -> frame_err pulse, return to IDLE, no response sent.
- Checksum check, in the cycle after CHK arrives:
  - Match with ADDR[7]=0: reg_wr_en=1 for exactly one cycle, reg_addr=ADDR[6:0], reg_wdata={DHI,DLO}; response byte = 0x06 (ACK).
  - Mismatch, or ADDR[7]=1 when the feature is absent: no write; frame_err pulse; response byte = 0x15 (NAK).
  - reg_addr/reg_wdata hold their last values between writes.
- RESP_ISSUE: waits while tx_busy=1. When tx_busy=0, drives tx_en=1 for one cycle with tx_data = response byte, then -> RESP_HOLD.
- RESP_HOLD: leaves on the first cycle tx_busy=1, or after TX_GUARD cycles. Next state is RESP_ISSUE if more response bytes remain, else IDLE.
- rx_valid during RESP_* states: byte dropped. No partial-frame state is kept.
- rx_valid in the same cycle as a timeout expiry: timeout wins; the byte is dropped.
- A 0xA5 byte inside a frame is data, not resync.
- Latency: last frame byte strobe -> reg_wr_en = 1 cycle; -> tx_en at least 2 cycles.
- Reset asserted mid-frame or mid-response: immediate return to IDLE with outputs 0. A transmit already in progress in the transmitter is not cancelled.

Optional Feature:
- Macro: UART_CMD_READBACK_EN.
- Defined:
  - Adds input port reg_rdata[15:0] and output reg_rd_en (1).
  - A valid frame with ADDR[7]=1 pulses reg_rd_en for one cycle, with reg_addr set, and does not write.
  - reg_rdata is sampled on the following cycle.
  - Response is 3 bytes: ACK, rdata[15:8], rdata[7:0], each with its own RESP_ISSUE/RESP_HOLD pass.
- Undefined: ports absent; ADDR[7]=1 frames are NAKed with a frame_err pulse.

Decomposition:
- Package uart_cmd_pkg: SYNC_BYTE, ACK_BYTE, NAK_BYTE localparams; FSM state enum typedef; frame field widths.
- Sub-module uart_cmd_tx_seq: RESP_ISSUE/RESP_HOLD handshake with the transmitter. It takes a byte-valid/ready pair and owns the TX_GUARD counter.

Test Plan:
- Frame A5 12 34 56 70 (CHK = 12^34^56 = 70) -> one reg_wr_en pulse, reg_addr=0x12, reg_wdata=0x3456; tx_en once with tx_data=0x06.
- Same frame with CHK=0x71 -> no reg_wr_en; frame_err pulse; tx_data=0x15.
- Bytes 00 FF A5 01 00 02 03 -> leading junk ignored; write addr 0x01, data 0x0002, ACK.
- A5 01, then idle for TIMEOUT_CYCLES (set 100 in the bench) -> frame_err after the 100th cycle, no tx_en; a following valid frame is accepted.
- tx_busy held high for 500 cycles when a response is due -> tx_en asserted only after tx_busy falls, exactly one pulse.
- With UART_CMD_READBACK_EN: A5 85 00 00 85, reg_rdata=0xBEEF -> reg_rd_en pulse at addr 0x05; tx_data sequence 06, BE, EF.
